// File: rtl/time_pkg.sv
// time_pkg: shared definitions for the time-of-day core.
// Holds the command opcodes, the field limits and widths of the hh:mm:ss
// registers, the PAUSED/RUN state encoding and a small range-check helper.
package time_pkg;

  // Command opcodes driven by the button/opcode decoder
  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_SET_SEC  = 4'd1;
  localparam logic [3:0] OP_SET_MIN  = 4'd2;
  localparam logic [3:0] OP_SET_HOUR = 4'd3;
  localparam logic [3:0] OP_CLR      = 4'd4;
  localparam logic [3:0] OP_PAUSE    = 4'd5;
  localparam logic [3:0] OP_RUN      = 4'd6;
  localparam logic [3:0] OP_INC_MIN  = 4'd7;
  localparam logic [3:0] OP_INC_HOUR = 4'd8;

  // Output field widths
  localparam int SEC_W  = 7;
  localparam int MIN_W  = 7;
  localparam int HOUR_W = 5;

  // Field limits
  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } run_state_e;

  // True when a 7-bit operand lies within 0..max
  function automatic logic in_range(input logic [6:0] val, input logic [6:0] max);
    return (val <= max);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-(MAX+1) up-counter used for the sec, min and hour fields.
// Ports:
//   clk      in  1  system clock, rising edge
//   rst      in  1  asynchronous active-high reset, clears q
//   load     in  1  load load_val (has priority over inc)
//   load_val in  W  value to load
//   inc      in  1  advance by one, wrapping MAX -> 0
//   q        out W  registered count
//   carry    out 1  combinational: inc && q == MAX
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] q_d;

  assign carry = inc && (q == MAX_V);

  // Next count: load wins over increment, otherwise hold
  always_comb begin
    q_d = q;
    if (load) begin
      q_d = load_val;
    end else if (inc) begin
      q_d = (q == MAX_V) ? {W{1'b0}} : (q + W'(1));
    end else begin
      q_d = q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: time-of-day core of the alarm clock.
// Runs hh:mm:ss from an internal 1 Hz prescaler and executes set/run commands.
// Ports:
//   clk       in  1  system clock, rising edge
//   rst       in  1  asynchronous active-high reset
//   op        in  4  command opcode, sampled when op_valid=1
//   op_valid  in  1  single-cycle command strobe
//   set_val   in  7  operand for SET_SEC / SET_MIN / SET_HOUR
//   sec       out 7  seconds 0..59
//   min       out 7  minutes 0..59
//   hour      out 5  hours 0..23
//   running   out 1  1 in RUN state
//   sec_pulse out 1  one cycle, with each tick-driven seconds update
//   err       out 1  one cycle, after an unknown opcode or out-of-range operand
module time_keeper #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] op,
  input  logic       op_valid,
  input  logic [6:0] set_val,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [4:0] hour,
  output logic       running,
  output logic       sec_pulse,
  output logic       err
);

  import time_pkg::*;

  localparam int              PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   TC = PW'(CLK_HZ - 1);

  run_state_e    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          pend_q, pend_d;
  logic          running_q, sec_pulse_q, err_q;

  logic ld_sec_s, ld_min_s, ld_hour_s, clr_s;
  logic inc_min_cmd_s, inc_hour_cmd_s, run_cmd_s, pause_cmd_s, bad_s;
  logic tick_s, adv_s;
  logic sec_carry_s, min_carry_s, hour_carry_unused_s;

  // Command decode; invalid operands and unknown opcodes only raise err
  always_comb begin
    ld_sec_s       = 1'b0;
    ld_min_s       = 1'b0;
    ld_hour_s      = 1'b0;
    clr_s          = 1'b0;
    inc_min_cmd_s  = 1'b0;
    inc_hour_cmd_s = 1'b0;
    run_cmd_s      = 1'b0;
    pause_cmd_s    = 1'b0;
    bad_s          = 1'b0;
    if (op_valid) begin
      case (op)
        OP_NOP:      bad_s = 1'b0;
        OP_SET_SEC:  begin
          ld_sec_s = in_range(set_val, SEC_MAX);
          bad_s    = !in_range(set_val, SEC_MAX);
        end
        OP_SET_MIN:  begin
          ld_min_s = in_range(set_val, MIN_MAX);
          bad_s    = !in_range(set_val, MIN_MAX);
        end
        OP_SET_HOUR: begin
          // Comparing the full 7 bits also rejects set_val[6:5] != 0
          ld_hour_s = in_range(set_val, {2'b00, HOUR_MAX});
          bad_s     = !in_range(set_val, {2'b00, HOUR_MAX});
        end
        OP_CLR:      clr_s          = 1'b1;
        OP_PAUSE:    pause_cmd_s    = 1'b1;
        OP_RUN:      run_cmd_s      = 1'b1;
        OP_INC_MIN:  inc_min_cmd_s  = 1'b1;
        OP_INC_HOUR: inc_hour_cmd_s = 1'b1;
        default:     bad_s          = 1'b1;
      endcase
    end else begin
      bad_s = 1'b0;
    end
  end

  assign tick_s = (state_q == ST_RUN) && (presc_q == TC);

  // A tick (fresh or deferred) advances time only in a command-free cycle
  assign adv_s = !op_valid && (tick_s || pend_q);

  // Prescaler and deferred-tick bookkeeping
  always_comb begin
    presc_d = presc_q;
    pend_d  = 1'b0;
    if (clr_s || ld_sec_s) begin
      presc_d = {PW{1'b0}};
    end else if (state_q == ST_RUN) begin
      presc_d = tick_s ? {PW{1'b0}} : (presc_q + PW'(1));
    end else begin
      presc_d = presc_q;
    end
    // Keep a colliding tick for later unless the command restarts the second
    if (op_valid && (tick_s || pend_q) && !(clr_s || ld_sec_s)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = 1'b0;
    end
  end

  // PAUSED/RUN next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSED: begin
        if (run_cmd_s) state_d = ST_RUN;
        else           state_d = ST_PAUSED;
      end
      ST_RUN: begin
        if (pause_cmd_s) state_d = ST_PAUSED;
        else             state_d = ST_RUN;
      end
      default: state_d = ST_PAUSED;
    endcase
  end

  // State, prescaler and registered flag outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PAUSED;
      presc_q     <= {PW{1'b0}};
      pend_q      <= 1'b0;
      running_q   <= 1'b0;
      sec_pulse_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      pend_q      <= pend_d;
      running_q   <= (state_d == ST_RUN);
      sec_pulse_q <= adv_s;
      err_q       <= bad_s;
    end
  end

  mod_counter #(.MAX(int'(SEC_MAX)), .W(SEC_W)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_sec_s || clr_s),
    .load_val (clr_s ? 7'd0 : set_val),
    .inc      (adv_s),
    .q        (sec),
    .carry    (sec_carry_s)
  );

  // INC_MIN also produces a carry at 59, but only tick carries reach hour
  mod_counter #(.MAX(int'(MIN_MAX)), .W(MIN_W)) u_min (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_min_s || clr_s),
    .load_val (clr_s ? 7'd0 : set_val),
    .inc      (sec_carry_s || inc_min_cmd_s),
    .q        (min),
    .carry    (min_carry_s)
  );

  mod_counter #(.MAX(int'(HOUR_MAX)), .W(HOUR_W)) u_hour (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_hour_s || clr_s),
    .load_val (clr_s ? 5'd0 : set_val[4:0]),
    .inc      ((min_carry_s && adv_s) || inc_hour_cmd_s),
    .q        (hour),
    .carry    (hour_carry_unused_s)
  );

  assign running   = running_q;
  assign sec_pulse = sec_pulse_q;
  assign err       = err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper with CLK_HZ=10.
module tb_time_keeper;
  import time_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] op = 4'd0;
  logic       op_valid = 1'b0;
  logic [6:0] set_val = 7'd0;
  logic [6:0] sec, min;
  logic [4:0] hour;
  logic       running, sec_pulse, err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  time_keeper #(.CLK_HZ(10)) dut (
    .clk(clk), .rst(rst), .op(op), .op_valid(op_valid), .set_val(set_val),
    .sec(sec), .min(min), .hour(hour),
    .running(running), .sec_pulse(sec_pulse), .err(err)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one command; returns just after the edge that sampled it
  task automatic cmd(input logic [3:0] o, input logic [6:0] v);
    op = o; set_val = v; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = OP_NOP; set_val = 7'd0;
  endtask

  task automatic clean();
    cmd(OP_PAUSE, 7'd0);
    cmd(OP_CLR, 7'd0);
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1;
    #2;
    checks++;
    if ({hour, min, sec} !== 19'd0) $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", hour, min, sec);
    else passed++;
    checks++;
    if ({running, sec_pulse, err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {running, sec_pulse, err});
    else passed++;
    step(2);
    rst = 1'b0;
    cmd(OP_SET_MIN, 7'd7);
    cmd(OP_RUN, 7'd0);
    step(12);
    checks++;
    if ({hour, min, sec} !== {5'd0, 7'd7, 7'd1}) $display("FAIL reset_precount: got %0d:%0d:%0d want 0:7:1", hour, min, sec);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({hour, min, sec, running} !== 20'd0) $display("FAIL reset_midcount: got %0d:%0d:%0d run=%b want 0:0:0 run=0", hour, min, sec, running);
    else passed++;
    step(2);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (sec_pulse) pulses++;
    end
    checks++;
    if ({pulses, 7'(sec), running} !== {32'd0, 7'd0, 1'b0}) $display("FAIL reset_no_tick: got pulses=%0d sec=%0d run=%b want 0 0 0", pulses, sec, running);
    else passed++;
  endtask

  task automatic test_basic();
    cmd(OP_RUN, 7'd0);
    checks++;
    if (running !== 1'b1) $display("FAIL basic_running: got %b want 1", running);
    else passed++;
    step(9);
    checks++;
    if ({sec, sec_pulse} !== {7'd0, 1'b0}) $display("FAIL basic_before_tick: got sec=%0d pulse=%b want 0 0", sec, sec_pulse);
    else passed++;
    step(1);
    checks++;
    if ({sec, sec_pulse} !== {7'd1, 1'b1}) $display("FAIL basic_first_tick: got sec=%0d pulse=%b want 1 1", sec, sec_pulse);
    else passed++;
    step(1);
    checks++;
    if (sec_pulse !== 1'b0) $display("FAIL basic_pulse_width: got %b want 0", sec_pulse);
    else passed++;
    step(19);
    checks++;
    if (sec !== 7'd3) $display("FAIL basic_30_cycles: got sec=%0d want 3", sec);
    else passed++;
    clean();
  endtask

  task automatic test_rollover();
    int pulses;
    cmd(OP_SET_HOUR, 7'd23);
    cmd(OP_SET_MIN, 7'd59);
    cmd(OP_SET_SEC, 7'd59);
    checks++;
    if ({hour, min, sec} !== {5'd23, 7'd59, 7'd59}) $display("FAIL roll_set: got %0d:%0d:%0d want 23:59:59", hour, min, sec);
    else passed++;
    cmd(OP_RUN, 7'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sec_pulse) pulses++;
    end
    checks++;
    if ({hour, min, sec} !== 19'd0) $display("FAIL roll_wrap: got %0d:%0d:%0d want 0:0:0", hour, min, sec);
    else passed++;
    checks++;
    if ({pulses, sec_pulse} !== {32'd1, 1'b1}) $display("FAIL roll_pulse: got pulses=%0d now=%b want 1 1", pulses, sec_pulse);
    else passed++;
    clean();
  endtask

  task automatic test_range();
    cmd(OP_SET_SEC, 7'd12);
    checks++;
    if ({sec, err} !== {7'd12, 1'b0}) $display("FAIL range_set_sec: got sec=%0d err=%b want 12 0", sec, err);
    else passed++;
    cmd(OP_SET_SEC, 7'd60);
    checks++;
    if ({sec, err} !== {7'd12, 1'b1}) $display("FAIL range_sec60: got sec=%0d err=%b want 12 1", sec, err);
    else passed++;
    step(1);
    checks++;
    if (err !== 1'b0) $display("FAIL range_err_width: got %b want 0", err);
    else passed++;
    cmd(OP_SET_HOUR, 7'd24);
    checks++;
    if ({hour, err} !== {5'd0, 1'b1}) $display("FAIL range_hour24: got hour=%0d err=%b want 0 1", hour, err);
    else passed++;
    cmd(OP_SET_HOUR, 7'd96);
    checks++;
    if ({hour, err} !== {5'd0, 1'b1}) $display("FAIL range_hour_hibits: got hour=%0d err=%b want 0 1", hour, err);
    else passed++;
    cmd(OP_SET_MIN, 7'd59);
    checks++;
    if ({min, err} !== {7'd59, 1'b0}) $display("FAIL range_min59: got min=%0d err=%b want 59 0", min, err);
    else passed++;
    cmd(4'b1010, 7'd5);
    checks++;
    if ({hour, min, sec, err} !== {5'd0, 7'd59, 7'd12, 1'b1}) $display("FAIL range_bad_op: got %0d:%0d:%0d err=%b want 0:59:12 1", hour, min, sec, err);
    else passed++;
    cmd(OP_INC_MIN, 7'd0);
    checks++;
    if ({hour, min, sec, err} !== {5'd0, 7'd0, 7'd12, 1'b0}) $display("FAIL range_inc_min_wrap: got %0d:%0d:%0d err=%b want 0:0:12 0", hour, min, sec, err);
    else passed++;
    cmd(OP_SET_HOUR, 7'd23);
    cmd(OP_INC_HOUR, 7'd0);
    checks++;
    if ({hour, min, sec} !== {5'd0, 7'd0, 7'd12}) $display("FAIL range_inc_hour_wrap: got %0d:%0d:%0d want 0:0:12", hour, min, sec);
    else passed++;
    clean();
  endtask

  task automatic test_collision();
    int pulses;
    cmd(OP_SET_MIN, 7'd5);
    cmd(OP_SET_SEC, 7'd30);
    cmd(OP_RUN, 7'd0);
    step(9);
    cmd(OP_INC_MIN, 7'd0);
    checks++;
    if ({hour, min, sec, sec_pulse} !== {5'd0, 7'd6, 7'd30, 1'b0}) $display("FAIL coll_cmd_first: got %0d:%0d:%0d pulse=%b want 0:6:30 0", hour, min, sec, sec_pulse);
    else passed++;
    step(1);
    checks++;
    if ({hour, min, sec, sec_pulse} !== {5'd0, 7'd6, 7'd31, 1'b1}) $display("FAIL coll_deferred: got %0d:%0d:%0d pulse=%b want 0:6:31 1", hour, min, sec, sec_pulse);
    else passed++;
    step(8);
    cmd(OP_CLR, 7'd0);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (sec_pulse) pulses++;
    end
    checks++;
    if ({hour, min, sec, 8'(pulses)} !== {19'd0, 8'd0}) $display("FAIL coll_clr_discard: got %0d:%0d:%0d pulses=%0d want 0:0:0 0", hour, min, sec, pulses);
    else passed++;
    cmd(OP_PAUSE, 7'd0);
    checks++;
    if ({running, sec, sec_pulse} !== {1'b0, 7'd0, 1'b0}) $display("FAIL coll_pause_cmd: got run=%b sec=%0d pulse=%b want 0 0 0", running, sec, sec_pulse);
    else passed++;
    step(1);
    checks++;
    if ({sec, sec_pulse} !== {7'd1, 1'b1}) $display("FAIL coll_pause_pending: got sec=%0d pulse=%b want 1 1", sec, sec_pulse);
    else passed++;
    clean();
  endtask

  task automatic test_pause();
    int pulses;
    cmd(OP_RUN, 7'd0);
    step(3);
    cmd(OP_PAUSE, 7'd0);  // prescaler is left holding 4
    checks++;
    if (running !== 1'b0) $display("FAIL pause_running: got %b want 0", running);
    else passed++;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (sec_pulse) pulses++;
    end
    checks++;
    if ({hour, min, sec, 8'(pulses)} !== {19'd0, 8'd0}) $display("FAIL pause_hold: got %0d:%0d:%0d pulses=%0d want 0:0:0 0", hour, min, sec, pulses);
    else passed++;
    cmd(OP_RUN, 7'd0);
    step(5);
    checks++;
    if (sec !== 7'd0) $display("FAIL pause_resume_early: got sec=%0d want 0", sec);
    else passed++;
    step(1);
    checks++;
    if ({sec, sec_pulse} !== {7'd1, 1'b1}) $display("FAIL pause_resume_tick: got sec=%0d pulse=%b want 1 1", sec, sec_pulse);
    else passed++;
    clean();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_rollover();
    test_range();
    test_collision();
    test_pause();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
